// File: rtl/regfile_access_ctrl.sv
// Command/response front end for a register file with a one-cycle registered read.
// Define REGFILE_WRITE_VERIFY_EN to read back every write and flag mismatches on Rsp_Err.
module regfile_access_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic              Cmd_Wr,
    input  logic [ADDR_W-1:0] Cmd_Addr,
    input  logic [DATA_W-1:0] Cmd_WrData,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [DATA_W-1:0] Rsp_RdData,
    output logic              Rsp_Err,
    output logic              Busy,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
`ifdef REGFILE_WRITE_VERIFY_EN
        ,
        VERIFY_RD,
        VERIFY_CAP
`endif
    } state_t;

    state_t            state_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
`ifdef REGFILE_WRITE_VERIFY_EN
    logic              rsp_err_q;
`endif

    // Strobes are registered: they are set on the edge entering the state that owns them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef REGFILE_WRITE_VERIFY_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Cmd_Valid) begin
                        addr_q  <= Cmd_Addr;
                        wdata_q <= Cmd_WrData;
`ifdef REGFILE_WRITE_VERIFY_EN
                        rsp_err_q <= 1'b0;
`endif
                        if (Cmd_Wr) begin
                            state_q <= WRITE;
                            wr_en_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
`ifdef REGFILE_WRITE_VERIFY_EN
                    state_q <= VERIFY_RD;
                    rd_en_q <= 1'b1;
`else
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
`endif
                end
                READ: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= RdData;
                end
`ifdef REGFILE_WRITE_VERIFY_EN
                VERIFY_RD: begin
                    state_q <= VERIFY_CAP;
                end
                VERIFY_CAP: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= RdData;
                    rsp_err_q   <= (RdData != wdata_q);
                end
`endif
                RESP: begin
                    if (Rsp_Ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Cmd_Ready  = (state_q == IDLE);
    assign Busy       = (state_q != IDLE);
    assign WrEn       = wr_en_q;
    assign RdEn       = rd_en_q;
    assign Address    = addr_q;
    assign WrData     = wdata_q;
    assign Rsp_Valid  = rsp_valid_q;
    assign Rsp_RdData = rsp_data_q;
`ifdef REGFILE_WRITE_VERIFY_EN
    assign Rsp_Err    = rsp_err_q;
`else
    assign Rsp_Err    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed + random bench for regfile_access_ctrl with a simple register-file model.
module tb_regfile_access_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Cmd_Valid = 1'b0;
    logic          Cmd_Ready;
    logic          Cmd_Wr = 1'b0;
    logic [AW-1:0] Cmd_Addr = '0;
    logic [DW-1:0] Cmd_WrData = '0;
    logic          Rsp_Valid;
    logic          Rsp_Ready = 1'b0;
    logic [DW-1:0] Rsp_RdData;
    logic          Rsp_Err;
    logic          Busy;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [DW-1:0] WrData;
    logic [DW-1:0] RdData;

    regfile_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Wr(Cmd_Wr),
        .Cmd_Addr(Cmd_Addr), .Cmd_WrData(Cmd_WrData),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_RdData(Rsp_RdData),
        .Rsp_Err(Rsp_Err), .Busy(Busy),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData), .RdData(RdData)
    );

    always #5 CLK = ~CLK;

`ifdef REGFILE_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    // Register file: synchronous write, one-cycle registered read; corrupt flips bit 0 of readback.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            corrupt = 1'b0;
    always @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        if (RdEn) RdData <= mem[Address] ^ {{(DW-1){1'b0}}, corrupt};
    end

    int            wr_pulses = 0;
    int            rd_pulses = 0;
    bit            both_hi = 1'b0;
    logic [AW-1:0] wr_addr_seen;
    logic [DW-1:0] wr_data_seen;
    always @(negedge CLK) begin
        if (WrEn) begin
            wr_pulses++;
            wr_addr_seen = Address;
            wr_data_seen = WrData;
        end
        if (RdEn) rd_pulses++;
        if (WrEn && RdEn) both_hi = 1'b1;
    end

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command through its full handshake; expectations come from the caller's model.
    task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, input bit spam, input bit early_rdy,
                          input logic [DW-1:0] exp_data, input logic exp_err, input int exp_lat);
        int            edges;
        int            wr0;
        int            rd0;
        logic [DW-1:0] held;
        @(negedge CLK);
        chk("idle_rsp_valid", 32'(Rsp_Valid), 32'd0);
        chk("idle_cmd_ready", 32'(Cmd_Ready), 32'd1);
        chk("idle_busy", 32'(Busy), 32'd0);
        wr0 = wr_pulses;
        rd0 = rd_pulses;
        Cmd_Valid = 1'b1; Cmd_Wr = wr; Cmd_Addr = a; Cmd_WrData = d;
        @(posedge CLK);
        #1;
        if (spam) begin
            Cmd_Wr = 1'b1; Cmd_Addr = a + 3'd1; Cmd_WrData = ~d;
        end else begin
            Cmd_Valid = 1'b0;
        end
        if (early_rdy) Rsp_Ready = 1'b1;
        edges = 1;
        @(negedge CLK);
        while (!Rsp_Valid && edges < 12) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        chk("rsp_latency", 32'(edges), 32'(exp_lat));
        chk("rsp_valid", 32'(Rsp_Valid), 32'd1);
        chk("rsp_data", 32'(Rsp_RdData), 32'(exp_data));
        chk("rsp_err", 32'(Rsp_Err), 32'(exp_err));
        held = Rsp_RdData;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("hold_valid", 32'(Rsp_Valid), 32'd1);
            chk("hold_data", 32'(Rsp_RdData), 32'(held));
            chk("hold_cmd_ready", 32'(Cmd_Ready), 32'd0);
            chk("hold_busy", 32'(Busy), 32'd1);
        end
        Rsp_Ready = 1'b1;
        @(posedge CLK);
        #1;
        Rsp_Ready = 1'b0;
        Cmd_Valid = 1'b0;
        chk("wr_pulses", 32'(wr_pulses - wr0), wr ? 32'd1 : 32'd0);
        chk("rd_pulses", 32'(rd_pulses - rd0), (!wr || VERIFY) ? 32'd1 : 32'd0);
        if (wr) begin
            chk("wr_addr", 32'(wr_addr_seen), 32'(a));
            chk("wr_data", 32'(wr_data_seen), 32'(d));
        end
    endtask

    // Expected response of a write derived from the block's contract.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold,
                            input bit early_rdy);
        ref_mem[a] = d;
        do_cmd(1'b1, a, d, hold, 1'b0, early_rdy, VERIFY ? d : '0, 1'b0, VERIFY ? 4 : 2);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold, input bit spam, input bit early_rdy);
        do_cmd(1'b0, a, '0, hold, spam, early_rdy, ref_mem[a], 1'b0, 3);
    endtask

    initial begin
        int  rd0;
        int  wr0;
        bit  saw_valid;
        // Commands under reset must not be accepted.
        Cmd_Valid = 1'b1; Cmd_Wr = 1'b1; Cmd_Addr = 3'd5; Cmd_WrData = 16'hFFFF;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
        chk("rst_rsp_err", 32'(Rsp_Err), 32'd0);
        chk("rst_rsp_data", 32'(Rsp_RdData), 32'd0);
        chk("rst_wren", 32'(WrEn), 32'd0);
        chk("rst_rden", 32'(RdEn), 32'd0);
        chk("rst_addr", 32'(Address), 32'd0);
        chk("rst_wrdata", 32'(WrData), 32'd0);
        chk("rst_no_pulses", 32'(wr_pulses + rd_pulses), 32'd0);
        RST = 1'b0;
        Cmd_Valid = 1'b0;

        do_write(3'd3, 16'hA5A5, 0, 1'b0);
        do_read(3'd3, 0, 1'b0, 1'b0);
        do_read(3'd3, 5, 1'b1, 1'b0);
        chk("spam_not_written", 32'(mem[3'd4] === 16'h5A5A), 32'd0);

        // Reset while in READ: abort with no response.
        @(negedge CLK);
        Cmd_Valid = 1'b1; Cmd_Wr = 1'b0; Cmd_Addr = 3'd3;
        @(posedge CLK);
        #1 Cmd_Valid = 1'b0;
        @(negedge CLK);
        chk("abort_in_read_rden", 32'(RdEn), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        @(negedge CLK);
        chk("abort_rden", 32'(RdEn), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_cmd_ready", 32'(Cmd_Ready), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (Rsp_Valid) saw_valid = 1'b1;
            @(negedge CLK);
        end
        chk("abort_no_rsp", 32'(saw_valid), 32'd0);
        chk("abort_no_pulse", 32'((rd_pulses - rd0) + (wr_pulses - wr0)), 32'd0);

        for (int a = 0; a < 8; a++) do_write(AW'(a), DW'(a), 0, 1'b0);
        for (int a = 0; a < 8; a++) do_read(AW'(a), 0, 1'b0, 1'b0);

`ifdef REGFILE_WRITE_VERIFY_EN
        corrupt = 1'b1;
        ref_mem[7] = 16'h1234;
        do_cmd(1'b1, 3'd7, 16'h1234, 1, 1'b0, 1'b0, 16'h1235, 1'b1, 4);
        corrupt = 1'b0;
        do_read(3'd7, 0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            int            hold;
            bit            early;
            a     = AW'($urandom_range(7, 0));
            hold  = $urandom_range(3, 0);
            early = (hold == 0) && ($urandom_range(1, 0) == 1);
            if ($urandom_range(1, 0) == 1) do_write(a, DW'($urandom), hold, early);
            else do_read(a, hold, 1'b0, early);
        end

        @(negedge CLK);
        chk("never_both_en", 32'(both_hi), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 16, register-file data width.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Cmd_Valid  input  1  command request.
REQ-006 SHALL have port Cmd_Ready  output  1  command accept; high only in IDLE.
REQ-007 SHALL have port Cmd_Wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port Cmd_Addr  input  ADDR_W  target register.
REQ-009 SHALL have port Cmd_WrData  input  DATA_W  write data.
REQ-010 SHALL have port Rsp_Valid  output  1  response available.
REQ-011 SHALL have port Rsp_Ready  input  1  response consumed.
REQ-012 SHALL have port Rsp_RdData  output  DATA_W  read data or write readback.
REQ-013 SHALL have port Rsp_Err  output  1  write-verify mismatch flag.
REQ-014 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have ports WrEn, RdEn (output 1), Address (output ADDR_W), WrData (output DATA_W), RdData (input DATA_W) driving one register file with a one-cycle registered read.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ, CAPTURE, RESP, plus VERIFY_RD, VERIFY_CAP under the macro.
REQ-017 SHALL accept a command on a rising edge with Cmd_Valid=1 and Cmd_Ready=1, latch Cmd_Wr/Cmd_Addr/Cmd_WrData, and go to WRITE if Cmd_Wr=1, else READ.
REQ-018 WRITE SHALL drive WrEn=1, RdEn=0, Address/WrData from the latch for exactly one cycle, then go to RESP (or VERIFY_RD with the macro).
REQ-019 READ SHALL drive RdEn=1, WrEn=0 for exactly one cycle, then go to CAPTURE.
REQ-020 CAPTURE SHALL register RdData into Rsp_RdData, then go to RESP.
REQ-021 RESP SHALL hold Rsp_Valid=1 with stable Rsp_RdData/Rsp_Err until the edge where Rsp_Ready=1, then return to IDLE.
REQ-022 Latency SHALL be: write Rsp_Valid after the 2nd edge from accept; read Rsp_Valid after the 3rd edge; add 2 edges for a verified write.
REQ-023 A plain write response SHALL carry Rsp_RdData=0 and Rsp_Err=0.
REQ-024 WrEn and RdEn SHALL never be high in the same cycle; both SHALL be 0 outside WRITE/READ/VERIFY_RD.
REQ-025 Address/WrData SHALL hold the latched values from accept until the next accept.
REQ-026 Cmd_Valid while not IDLE SHALL be ignored; there SHALL be at most one outstanding command.
REQ-027 Rsp_Ready while Rsp_Valid=0 SHALL have no effect.
REQ-028 Back-to-back commands SHALL incur exactly one IDLE cycle between response handshake and the next accept.

Reset
REQ-029 On a rising edge with RST=1 the block SHALL enter IDLE, with WrEn=0, RdEn=0, Rsp_Valid=0, Rsp_Err=0, Rsp_RdData=0, Address=0, WrData=0, Busy=0, Cmd_Ready=1 from the following cycle.
REQ-030 RST during any state SHALL abort the command and discard a pending response, with no further WrEn/RdEn pulse.
REQ-031 Commands presented while RST=1 SHALL not be accepted.

Configuration
REQ-032 With macro REGFILE_WRITE_VERIFY_EN defined, a write SHALL continue WRITE -> VERIFY_RD (RdEn=1 one cycle) -> VERIFY_CAP (Rsp_RdData<=RdData, Rsp_Err<=(RdData!=latched WrData)) -> RESP.
REQ-033 Without REGFILE_WRITE_VERIFY_EN, the VERIFY states SHALL not exist and Rsp_Err SHALL be constant 0.

Verification
REQ-034 Write addr 3 data 16'hA5A5, Rsp_Ready=1 -> one WrEn pulse with Address=3 and WrData=A5A5, Rsp_Valid 2 edges after accept, Rsp_RdData=0.
REQ-035 Read addr 3 after REQ-034 -> one RdEn pulse, Rsp_RdData=16'hA5A5 3 edges after accept.
REQ-036 Hold Rsp_Ready=0 for 5 cycles on a read -> Rsp_Valid and data stable, Cmd_Ready=0, second Cmd_Valid ignored until handshake.
REQ-037 RST=1 in READ state -> next cycle IDLE, RdEn=0, Rsp_Valid never asserts for the aborted read.
REQ-038 With REGFILE_WRITE_VERIFY_EN, write 16'h1234 to addr 7 with model forcing readback 16'h1235 -> Rsp_Err=1, Rsp_RdData=16'h1235 after 4 edges.
REQ-039 All 8 addresses written with the address value then read back -> each read returns the address value, WrEn&RdEn never both high.
